// File: rtl/sal_cmd_sched_pkg.sv
// Shared SAL DDR parameters: command field types, scheduler command encoding
// and timing-counter widths.
package sal_cmd_sched_pkg;

    localparam int RA_W  = 16;
    localparam int CA_W  = 10;
    localparam int ID_W  = 4;
    localparam int LEN_W = 8;
    localparam int SEQ_W = 8;

    localparam int T_RRD_W = 4;
    localparam int T_CCD_W = 4;
    localparam int T_WTR_W = 4;
    localparam int T_RTW_W = 4;
    localparam int T_FAW_W = 6;

    localparam int FAW_DEPTH = 4;
    localparam int NUM_CLS   = 4;

    typedef logic [RA_W-1:0]  dram_ra_t;
    typedef logic [CA_W-1:0]  dram_ca_t;
    typedef logic [ID_W-1:0]  axi_id_t;
    typedef logic [LEN_W-1:0] axi_len_t;
    typedef logic [SEQ_W-1:0] seq_num_t;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } sched_cmd_t;

    // Arbitration classes, listed highest priority first.
    typedef enum logic [1:0] {
        CLS_COL = 2'd0,
        CLS_ACT = 2'd1,
        CLS_PRE = 2'd2,
        CLS_REF = 2'd3
    } sched_cls_t;

endpackage

// File: rtl/sal_timing_if.sv
// Inter-bank timing parameters (minus-one encoded) driven by the CSR block.
interface sal_timing_if;
    import sal_cmd_sched_pkg::*;

    logic [T_RRD_W-1:0] t_rrd_m1;
    logic [T_CCD_W-1:0] t_ccd_m1;
    logic [T_WTR_W-1:0] t_wtr_m1;
    logic [T_RTW_W-1:0] t_rtw_m1;
    logic [T_FAW_W-1:0] t_faw_m1;

    modport MON (input t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1, t_faw_m1);
endinterface

// File: rtl/sal_rr_arb.sv
// Round-robin selector: first requester at or after ptr wins (one-hot grant).
module sal_rr_arb #(
    parameter int NUM_BANKS = 4
) (
    input  logic [NUM_BANKS-1:0]         req,
    input  logic [$clog2(NUM_BANKS)-1:0] ptr,
    output logic [NUM_BANKS-1:0]         gnt
);
    localparam int BW = $clog2(NUM_BANKS);

    logic [BW-1:0] idx;

    // Walk from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            idx = ptr + BW'(i);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sal_timing_cntr.sv
// Loadable countdown timer saturating at zero; a load beats the decrement.
module sal_timing_cntr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/sal_cmd_sched.sv
// Inter-bank DDR command scheduler: class priority + per-class round robin,
// tRRD/tCCD/tWTR/tRTW gating; tFAW history only with SAL_FAW_CHECK_EN.
module sal_cmd_sched
    import sal_cmd_sched_pkg::*;
#(
    parameter int NUM_BANKS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    sal_timing_if.MON                    timing_if,
    input  logic [NUM_BANKS-1:0]         act_req_i,
    input  logic [NUM_BANKS-1:0]         rd_req_i,
    input  logic [NUM_BANKS-1:0]         wr_req_i,
    input  logic [NUM_BANKS-1:0]         pre_req_i,
    input  logic [NUM_BANKS-1:0]         ref_req_i,
    input  dram_ra_t [NUM_BANKS-1:0]     ra_i,
    input  dram_ca_t [NUM_BANKS-1:0]     ca_i,
    input  axi_id_t  [NUM_BANKS-1:0]     id_i,
    input  axi_len_t [NUM_BANKS-1:0]     len_i,
    input  seq_num_t [NUM_BANKS-1:0]     seq_num_i,
    output logic [NUM_BANKS-1:0]         act_gnt_o,
    output logic [NUM_BANKS-1:0]         rd_gnt_o,
    output logic [NUM_BANKS-1:0]         wr_gnt_o,
    output logic [NUM_BANKS-1:0]         pre_gnt_o,
    output logic [NUM_BANKS-1:0]         ref_gnt_o,
    output logic                         cmd_valid_o,
    output sched_cmd_t                   cmd_o,
    output logic [$clog2(NUM_BANKS)-1:0] bank_o,
    output dram_ra_t                     ra_o,
    output dram_ca_t                     ca_o,
    output axi_id_t                      id_o,
    output axi_len_t                     len_o,
    output seq_num_t                     seq_num_o
);
    localparam int BW = $clog2(NUM_BANKS);

    if (NUM_BANKS < 2 || NUM_BANKS > 16 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_param
        $error("sal_cmd_sched: NUM_BANKS must be a power of two in 2..16");
    end

    logic [NUM_BANKS-1:0] col_any, eff_rd, eff_wr, eff_act, eff_pre, eff_ref;
    logic [NUM_CLS-1:0][NUM_BANKS-1:0] cls_req, cls_gnt;
    logic [NUM_CLS-1:0][BW-1:0] ptr_q;
    logic [NUM_BANKS-1:0] win;
    logic [BW-1:0] win_bank;
    sched_cls_t win_cls;
    sched_cmd_t win_cmd;
    logic fire, act_fire, rd_fire, wr_fire;
    logic rrd_zero, ccd_zero, wtr_zero, rtw_zero, faw_ok;
    logic rd_ok, wr_ok, act_ok;

    // Each bank competes only with its highest-priority request; a bank raising
    // both RD and WR is served as RD.
    always_comb begin
        col_any = rd_req_i | wr_req_i;
        eff_rd  = rd_req_i;
        eff_wr  = wr_req_i & ~rd_req_i;
        eff_act = act_req_i & ~col_any;
        eff_pre = pre_req_i & ~col_any & ~act_req_i;
        eff_ref = ref_req_i & ~col_any & ~act_req_i & ~pre_req_i;
    end

    assign rd_ok  = ccd_zero & wtr_zero;
    assign wr_ok  = ccd_zero & rtw_zero;
    assign act_ok = rrd_zero & faw_ok;

    always_comb begin
        cls_req          = '0;
        cls_req[CLS_COL] = (eff_rd & {NUM_BANKS{rd_ok}}) | (eff_wr & {NUM_BANKS{wr_ok}});
        cls_req[CLS_ACT] = eff_act & {NUM_BANKS{act_ok}};
        cls_req[CLS_PRE] = eff_pre;
        cls_req[CLS_REF] = eff_ref;
    end

    for (genvar c = 0; c < NUM_CLS; c++) begin : g_arb
        sal_rr_arb #(.NUM_BANKS(NUM_BANKS)) u_arb (
            .req (cls_req[c]),
            .ptr (ptr_q[c]),
            .gnt (cls_gnt[c])
        );
    end

    // Highest-priority class with any eligible requester takes the slot.
    always_comb begin
        win     = '0;
        win_cls = CLS_COL;
        for (int c = NUM_CLS - 1; c >= 0; c--) begin
            if (|cls_req[c]) begin
                win     = cls_gnt[c];
                win_cls = sched_cls_t'(c);
            end
        end
        if (!rst_n)
            win = '0;
    end

    always_comb begin
        win_bank = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (win[b]) win_bank = BW'(b);
    end

    assign rd_gnt_o  = (win_cls == CLS_COL) ? (win & eff_rd) : '0;
    assign wr_gnt_o  = (win_cls == CLS_COL) ? (win & eff_wr) : '0;
    assign act_gnt_o = (win_cls == CLS_ACT) ? win : '0;
    assign pre_gnt_o = (win_cls == CLS_PRE) ? win : '0;
    assign ref_gnt_o = (win_cls == CLS_REF) ? win : '0;

    assign fire     = |win;
    assign act_fire = |act_gnt_o;
    assign rd_fire  = |rd_gnt_o;
    assign wr_fire  = |wr_gnt_o;

    always_comb begin
        win_cmd = CMD_NOP;
        if (fire) begin
            case (win_cls)
                CLS_COL: win_cmd = rd_fire ? CMD_RD : CMD_WR;
                CLS_ACT: win_cmd = CMD_ACT;
                CLS_PRE: win_cmd = CMD_PRE;
                CLS_REF: win_cmd = CMD_REF;
                default: win_cmd = CMD_NOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr_q <= '0;
        else if (fire)
            ptr_q[win_cls] <= win_bank + 1'b1;
    end

    sal_timing_cntr #(.W(T_RRD_W)) u_rrd (.clk(clk), .rst_n(rst_n), .load(act_fire),
        .load_val(timing_if.t_rrd_m1), .zero(rrd_zero));
    sal_timing_cntr #(.W(T_CCD_W)) u_ccd (.clk(clk), .rst_n(rst_n), .load(rd_fire | wr_fire),
        .load_val(timing_if.t_ccd_m1), .zero(ccd_zero));
    sal_timing_cntr #(.W(T_WTR_W)) u_wtr (.clk(clk), .rst_n(rst_n), .load(wr_fire),
        .load_val(timing_if.t_wtr_m1), .zero(wtr_zero));
    sal_timing_cntr #(.W(T_RTW_W)) u_rtw (.clk(clk), .rst_n(rst_n), .load(rd_fire),
        .load_val(timing_if.t_rtw_m1), .zero(rtw_zero));

`ifdef SAL_FAW_CHECK_EN
    logic [FAW_DEPTH-1:0] faw_zero, faw_load;

    // A new ACT always claims the lowest expired history slot.
    always_comb begin
        faw_load = '0;
        for (int k = FAW_DEPTH - 1; k >= 0; k--) begin
            if (faw_zero[k]) begin
                faw_load    = '0;
                faw_load[k] = act_fire;
            end
        end
    end

    for (genvar k = 0; k < FAW_DEPTH; k++) begin : g_faw
        sal_timing_cntr #(.W(T_FAW_W)) u_faw (.clk(clk), .rst_n(rst_n), .load(faw_load[k]),
            .load_val(timing_if.t_faw_m1), .zero(faw_zero[k]));
    end

    assign faw_ok = |faw_zero;
`else
    assign faw_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!fire) begin
            cmd_valid_o <= 1'b0;
            cmd_o       <= CMD_NOP;
            bank_o      <= '0;
            ra_o        <= '0;
            ca_o        <= '0;
            id_o        <= '0;
            len_o       <= '0;
            seq_num_o   <= '0;
        end else begin
            cmd_valid_o <= 1'b1;
            cmd_o       <= win_cmd;
            bank_o      <= win_bank;
            ra_o        <= ra_i[win_bank];
            ca_o        <= ca_i[win_bank];
            id_o        <= id_i[win_bank];
            len_o       <= len_i[win_bank];
            seq_num_o   <= seq_num_i[win_bank];
        end
    end
endmodule

// File: doc/sal_cmd_sched.md
SAL_CMD_SCHED -- requirements
Module: SAL_CMD_SCHED

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, meaning the number of per-bank controllers arbitrated; legal values are 2..16, power of two.
REQ-002 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port timing_if  modport TIMING_IF.MON  -  supplies t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1, t_faw_m1.
REQ-005 SHALL have ports act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i  input  NUM_BANKS each  per-bank command requests.
REQ-006 SHALL have ports ra_i, ca_i, id_i, len_i, seq_num_i  input  NUM_BANKS x dram_ra_t/dram_ca_t/axi_id_t/axi_len_t/seq_num_t  per-bank command fields.
REQ-007 SHALL have ports act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o  output  NUM_BANKS each  one-hot grants.
REQ-008 SHALL have ports cmd_valid_o  output  1, cmd_o  output  sched_cmd_t, bank_o  output  log2(NUM_BANKS), ra_o, ca_o, id_o, len_o, seq_num_o  output  field types; these form the issued command toward the PHY.

Function
REQ-009 SHALL assert at most one grant bit across all five grant vectors per cycle.
REQ-010 SHALL generate grants combinationally in the same cycle as the request.
REQ-011 SHALL register the granted command, bank index and fields onto the cmd_*/field outputs one cycle after the grant, with cmd_valid_o high for exactly that cycle.
REQ-012 SHALL use the class priority RD/WR > ACT > PRE > REF, selecting the highest-priority class that has an eligible requester.
REQ-013 SHALL treat RD and WR as one column class and use one round-robin pointer per class (column, ACT, PRE, REF); after a grant, the pointer SHALL move to granted bank + 1 mod NUM_BANKS.
REQ-014 SHALL make ACT eligible only when the tRRD counter is zero and the tFAW check passes.
REQ-015 SHALL make RD eligible only when the tCCD and tWTR counters are zero, and WR eligible only when the tCCD and tRTW counters are zero.
REQ-016 SHALL load each counter with its _m1 value on the enabling grant and decrement it to 0, saturating at 0; tRRD loads on ACT, tCCD on RD or WR, tWTR on WR, tRTW on RD.
REQ-017 SHALL let a grant in the same cycle that a counter reaches zero reload that counter, with the reload winning over the decrement.
REQ-018 SHALL apply PRE and REF with no inter-bank timing checks; per-bank timing is owned by the bank controller.
REQ-019 SHALL, when a bank requests more than one class at once, consider only its highest-priority class.
REQ-020 SHALL drive field outputs to 0 when cmd_valid_o is low.

Reset
REQ-021 SHALL, while rst_n is low at posedge clk, clear all grants, clear cmd_valid_o, zero all counters, zero all RR pointers and clear the FAW window; grants SHALL stay 0 during reset.
REQ-022 SHALL, on reset mid-operation, discard any pending registered command so that no cmd_valid_o pulse follows.

Configuration
REQ-023 SHALL, with SAL_FAW_CHECK_EN defined, keep a 4-entry ACT history of countdown counters loaded with t_faw_m1, and block ACT while all 4 entries are non-zero.
REQ-024 SHALL, without SAL_FAW_CHECK_EN, remove the FAW history logic and treat the tFAW check as always passing.

Structure
REQ-025 SHALL place sched_cmd_t (CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF) and the counter width constants in the shared SAL DDR params package.
REQ-026 SHALL implement the round-robin selector as sub-module SAL_RR_ARB (parameter NUM_BANKS; inputs req vector and pointer; outputs one-hot grant), instantiated once per class.
REQ-027 SHALL implement all timing counters with the existing SAL_TIMING_CNTR.

Verification
REQ-028 SHALL cover: rd_req_i=4'b1010, pointer 0, no active timers -> rd_gnt_o=4'b0010; next cycle cmd_o=CMD_RD, bank_o=1.
REQ-029 SHALL cover: act_req_i=4'b0001 together with rd_req_i=4'b0100 -> rd_gnt_o=4'b0100; act_gnt_o=0 that cycle.
REQ-030 SHALL cover: t_rrd_m1=3, ACT to bank 0, then ACT held on bank 1 -> bank 1 granted exactly 4 cycles later.
REQ-031 SHALL cover: t_wtr_m1=5, WR granted, RD held -> RD granted 6 cycles later, while WR requests within that window are granted subject to tCCD.
REQ-032 SHALL cover: with SAL_FAW_CHECK_EN defined, t_rrd_m1=0 and t_faw_m1=19, 5 back-to-back ACTs -> the 5th ACT is granted 20 cycles after the 1st; without the macro, the 5th is granted at cycle 4.
REQ-033 SHALL cover: rst_n low in the cycle of a grant -> cmd_valid_o stays 0 next cycle and all counters read as met after reset.
